ghash_ctrl: RTL

//  GHASH sequencer that drives the Karatsuba GF(2^128) multiplier and consumes its 256-bit

---
 rtl/gcm_pkg.sv | 23 ++
 rtl/gf128_reduce.sv | 37 +++
 rtl/ghash_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/gcm_pkg.sv
// Shared GHASH definitions: field polynomial, sequencer states, bit-order helper.
package gcm_pkg;

    // Low-order terms of x^128 + x^7 + x^2 + x + 1 (the x^128 term is implicit).
    localparam logic [127:0] GF128_POLY = 128'h87;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_BLK = 2'd1,
        MUL_WAIT = 2'd2,
        DONE     = 2'd3
    } ghash_state_e;

    // GCM numbers bit 127 as coefficient x^0; swap to/from polynomial order.
    function automatic logic [127:0] bitrev128(input logic [127:0] v);
        logic [127:0] r;
        for (int i = 0; i < 128; i++) begin
            r[i] = v[127 - i];
        end
        return r;
    endfunction

endpackage

// File: rtl/gf128_reduce.sv
// Combinational reduction of an unreduced 256-bit carry-less product modulo
// x^128 + x^7 + x^2 + x + 1. Two XOR folding passes: the first folds bits
// 255..128 down, the second folds the bits 134..128 that the first pass creates.
module gf128_reduce
    import gcm_pkg::*;
(
    input  logic [255:0] prod_i,
    output logic [127:0] red_o
);

    logic [134:0] fold1_s;
    logic [6:0]   hi2_s;
    logic [127:0] fold2_s;

    // Fold the high half once, then fold the small overflow once more.
    always_comb begin
        fold1_s = {7'd0, prod_i[127:0]};
        for (int k = 0; k < 8; k++) begin
            if (GF128_POLY[k]) begin
                fold1_s = fold1_s ^ ({7'd0, prod_i[255:128]} << k);
            end else begin
                fold1_s = fold1_s;
            end
        end
        hi2_s   = fold1_s[134:128];
        fold2_s = fold1_s[127:0];
        for (int k = 0; k < 8; k++) begin
            if (GF128_POLY[k]) begin
                fold2_s = fold2_s ^ ({121'd0, hi2_s} << k);
            end else begin
                fold2_s = fold2_s;
            end
        end
        red_o = fold2_s;
    end

endmodule

// File: rtl/ghash_ctrl.sv
// GHASH sequencer: per accepted block computes Y = reduce((Y ^ X) * H) using an
// external multiplier with arbitrary latency; one product in flight at a time.
module ghash_ctrl
    import gcm_pkg::*;
#(
    parameter int WIDTH = 128
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic [WIDTH-1:0]   h_i,
    input  logic               blk_valid_i,
    output logic               blk_ready_o,
    input  logic [WIDTH-1:0]   blk_i,
    input  logic               blk_last_i,
    output logic               mul_en_o,
    output logic               mul_valid_o,
    output logic [WIDTH-1:0]   mul_a_o,
    output logic [WIDTH-1:0]   mul_b_o,
    input  logic               mul_valid_i,
    input  logic [2*WIDTH-1:0] mul_result_i,
    output logic               tag_valid_o,
    output logic [WIDTH-1:0]   tag_o,
    output logic               busy_o
);

    ghash_state_e     state_q, state_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] h_q, h_d;
    logic [WIDTH-1:0] mul_a_q, mul_a_d;
    logic [WIDTH-1:0] mul_b_q, mul_b_d;
    logic [WIDTH-1:0] tag_q, tag_d;
    logic             last_q, last_d;
    logic             mul_valid_q, mul_valid_d;
    logic             tag_valid_q, tag_valid_d;
    logic             blk_ready_q, blk_ready_d;
    logic             busy_q, busy_d;
    logic             mul_en_q, mul_en_d;
    logic [WIDTH-1:0] red_s;

    gf128_reduce u_reduce (
        .prod_i (mul_result_i),
        .red_o  (red_s)
    );

    // Next-state, datapath updates and next values of the registered outputs.
    always_comb begin
        state_d     = state_q;
        y_d         = y_q;
        h_d         = h_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        tag_d       = tag_q;
        last_d      = last_q;
        mul_valid_d = 1'b0;
        tag_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    h_d     = bitrev128(h_i);
                    y_d     = {WIDTH{1'b0}};
                    state_d = WAIT_BLK;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_BLK: begin
                if (blk_valid_i && blk_ready_q) begin
                    mul_a_d     = y_q ^ bitrev128(blk_i);
                    mul_b_d     = h_q;
                    mul_valid_d = 1'b1;
                    last_d      = blk_last_i;
                    state_d     = MUL_WAIT;
                end else begin
                    state_d = WAIT_BLK;
                end
            end
            MUL_WAIT: begin
                if (mul_valid_i) begin
                    y_d = red_s;
                    if (last_q) begin
                        tag_d       = bitrev128(red_s);
                        tag_valid_d = 1'b1;
                        state_d     = DONE;
                    end else begin
                        state_d = WAIT_BLK;
                    end
                end else begin
                    state_d = MUL_WAIT;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        blk_ready_d = (state_d == WAIT_BLK);
        busy_d      = (state_d == WAIT_BLK) || (state_d == MUL_WAIT);
        mul_en_d    = (state_d != IDLE);
    end

    // State, datapath and output registers; reset aborts any message in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            y_q         <= {WIDTH{1'b0}};
            h_q         <= {WIDTH{1'b0}};
            mul_a_q     <= {WIDTH{1'b0}};
            mul_b_q     <= {WIDTH{1'b0}};
            tag_q       <= {WIDTH{1'b0}};
            last_q      <= 1'b0;
            mul_valid_q <= 1'b0;
            tag_valid_q <= 1'b0;
            blk_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            mul_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            y_q         <= y_d;
            h_q         <= h_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            tag_q       <= tag_d;
            last_q      <= last_d;
            mul_valid_q <= mul_valid_d;
            tag_valid_q <= tag_valid_d;
            blk_ready_q <= blk_ready_d;
            busy_q      <= busy_d;
            mul_en_q    <= mul_en_d;
        end
    end

    assign blk_ready_o = blk_ready_q;
    assign mul_en_o    = mul_en_q;
    assign mul_valid_o = mul_valid_q;
    assign mul_a_o     = mul_a_q;
    assign mul_b_o     = mul_b_q;
    assign tag_valid_o = tag_valid_q;
    assign tag_o       = tag_q;
    assign busy_o      = busy_q;

endmodule
